// File: rtl/render_scheduler_pkg.sv
// rtl/render_scheduler_pkg.sv - shared map geometry defaults, scheduler states and cell type
package render_scheduler_pkg;

    localparam int MAP_WIDTH_DEF   = 13;
    localparam int MAP_HEIGHT_DEF  = 13;
    localparam int DIRTY_DEPTH_DEF = 8;
    localparam int TIMEOUT_DEF     = 2047;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FULL_ISSUE  = 3'd1,
        ST_FULL_WAIT   = 3'd2,
        ST_DIRTY_ISSUE = 3'd3,
        ST_DIRTY_WAIT  = 3'd4
    } sched_state_t;

    // One map cell as stored in the dirty FIFO: row in the upper nibble.
    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } cell_t;

endpackage

// File: rtl/render_scheduler_dirty_fifo.sv
// rtl/render_scheduler_dirty_fifo.sv - dirty-cell FIFO with flush that keeps a same-cycle push
module render_scheduler_dirty_fifo
    import render_scheduler_pkg::*;
#(
    parameter int DEPTH = DIRTY_DEPTH_DEF
) (
    input  logic  map_clk,
    input  logic  rstn,
    input  logic  push,
    input  logic  pop,
    input  logic  flush,
    input  cell_t din,
    output cell_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    cell_t       mem [DEPTH];

    // Pointer update: flush empties the queue; a push in the flush cycle becomes entry 0.
    always_ff @(posedge map_clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            rptr <= '0;
            wptr <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage write; during a flush the incoming cell lands at the reset write slot.
    always_ff @(posedge map_clk) begin
        if (push) mem[flush ? '0 : wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/render_scheduler.sv
// rtl/render_scheduler.sv - picks the next map cell to draw and drives the tile renderer handshake
module render_scheduler
    import render_scheduler_pkg::*;
#(
    parameter int MAP_WIDTH   = MAP_WIDTH_DEF,
    parameter int MAP_HEIGHT  = MAP_HEIGHT_DEF,
    parameter int DIRTY_DEPTH = DIRTY_DEPTH_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic       map_clk,
    input  logic       rstn,
    input  logic       full_req,
    input  logic       mark_valid,
    input  logic [3:0] mark_x,
    input  logic [3:0] mark_y,
    input  logic       tile_done,
    output logic       tile_start,
    output logic [3:0] grid_x,
    output logic [3:0] grid_y,
    output logic       busy,
    output logic       frame_done,
    output logic       ovf,
    output logic       timeout_err
);

    localparam int         TW     = $clog2(TIMEOUT + 1);
    localparam logic [3:0] LAST_X = 4'(MAP_WIDTH - 1);
    localparam logic [3:0] LAST_Y = 4'(MAP_HEIGHT - 1);

    sched_state_t  state;
    sched_state_t  state_nx;
    logic          pending_full;
    logic [TW-1:0] timer;

    logic  fifo_push;
    logic  fifo_pop;
    logic  fifo_flush;
    logic  fifo_full;
    logic  fifo_empty;
    cell_t fifo_dout;

    logic mark_ok;
    logic mark_lost;
    logic in_wait;
    logic tile_timed_out;
    logic tile_end;
    logic wait_end;
    logic sweep_start;
    logic advance;
    logic at_last;

    // Off-map marks are dropped here; a 5-bit compare keeps 16-wide maps correct.
    assign mark_ok = mark_valid
                  && ({1'b0, mark_x} < 5'(MAP_WIDTH))
                  && ({1'b0, mark_y} < 5'(MAP_HEIGHT));

    // A full FIFO still takes a mark if a slot frees up the same cycle (pop or flush).
    assign fifo_push  = mark_ok && (!fifo_full || fifo_pop || fifo_flush);
    assign mark_lost  = mark_ok && !fifo_push;
    assign fifo_flush = sweep_start;

    assign in_wait        = (state == ST_FULL_WAIT) || (state == ST_DIRTY_WAIT);
    assign tile_timed_out = (timer == TW'(TIMEOUT));
    assign tile_end       = tile_done || tile_timed_out;
    assign at_last        = (grid_x == LAST_X) && (grid_y == LAST_Y);
    assign busy           = (state != ST_IDLE) || pending_full || !fifo_empty;

    render_scheduler_dirty_fifo #(.DEPTH(DIRTY_DEPTH)) u_dirty_fifo (
        .map_clk (map_clk),
        .rstn    (rstn),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .din     ({mark_y, mark_x}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Scheduler state register.
    always_ff @(posedge map_clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next state and handshake strobes; full redraws outrank dirty cells in IDLE.
    always_comb begin
        state_nx    = state;
        tile_start  = 1'b0;
        frame_done  = 1'b0;
        sweep_start = 1'b0;
        fifo_pop    = 1'b0;
        advance     = 1'b0;
        wait_end    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending_full) begin
                    sweep_start = 1'b1;
                    state_nx    = ST_FULL_ISSUE;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_nx = ST_DIRTY_ISSUE;
                end
            end
            ST_FULL_ISSUE: begin
                tile_start = 1'b1;
                state_nx   = ST_FULL_WAIT;
            end
            ST_FULL_WAIT: begin
                if (tile_end) begin
                    wait_end = 1'b1;
                    if (at_last) begin
                        frame_done = 1'b1;
                        state_nx   = ST_IDLE;
                    end else begin
                        advance  = 1'b1;
                        state_nx = ST_FULL_ISSUE;
                    end
                end
            end
            ST_DIRTY_ISSUE: begin
                tile_start = 1'b1;
                state_nx   = ST_DIRTY_WAIT;
            end
            ST_DIRTY_WAIT: begin
                if (tile_end) begin
                    wait_end = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Grid position, tile timer, pending-sweep flag and sticky error flags.
    always_ff @(posedge map_clk or negedge rstn) begin
        if (!rstn) begin
            grid_x       <= '0;
            grid_y       <= '0;
            timer        <= '0;
            pending_full <= 1'b1;
            ovf          <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (sweep_start) begin
                grid_x <= '0;
                grid_y <= '0;
            end else if (fifo_pop) begin
                grid_x <= fifo_dout.x;
                grid_y <= fifo_dout.y;
            end else if (advance) begin
                if (grid_x == LAST_X) begin
                    grid_x <= '0;
                    grid_y <= grid_y + 4'd1;
                end else begin
                    grid_x <= grid_x + 4'd1;
                end
            end

            if (tile_start)   timer <= '0;
            else if (in_wait) timer <= timer + TW'(1);

            // A new request or a lost mark must win over the clear at sweep start.
            if (full_req || mark_lost) pending_full <= 1'b1;
            else if (sweep_start)      pending_full <= 1'b0;

            if (mark_lost) ovf <= 1'b1;
            if (wait_end && !tile_done && tile_timed_out) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_render_scheduler.sv
// tb/tb_render_scheduler.sv - randomized self-checking bench for render_scheduler
module tb_render_scheduler;

    localparam int W = 13;
    localparam int H = 13;

    logic       map_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       full_req = 1'b0;
    logic       mark_valid = 1'b0;
    logic [3:0] mark_x = '0;
    logic [3:0] mark_y = '0;
    logic       tile_done;
    logic       tile_start;
    logic [3:0] grid_x;
    logic [3:0] grid_y;
    logic       busy;
    logic       frame_done;
    logic       ovf;
    logic       timeout_err;

    int vectors = 0;
    int fails   = 0;

    logic [7:0] starts[$];
    int         frame_at[$];
    int         frames = 0;

    logic resp_en     = 1'b1;
    int   resp_fixed  = 0;
    logic manual_done = 1'b0;

    render_scheduler dut (
        .map_clk     (map_clk),
        .rstn        (rstn),
        .full_req    (full_req),
        .mark_valid  (mark_valid),
        .mark_x      (mark_x),
        .mark_y      (mark_y),
        .tile_done   (tile_done),
        .tile_start  (tile_start),
        .grid_x      (grid_x),
        .grid_y      (grid_y),
        .busy        (busy),
        .frame_done  (frame_done),
        .ovf         (ovf),
        .timeout_err (timeout_err)
    );

    always #5 map_clk = ~map_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Row-major cell k of a full sweep, {y,x}.
    function automatic logic [7:0] sweep_cell(int k);
        int m;
        m = k % (W * H);
        return {4'(m / W), 4'(m % W)};
    endfunction

    // Renderer model: logs every tile_start, answers with tile_done after a delay,
    // checks grid stability and start spacing, and records frame_done pulses.
    initial begin
        int         countdown;
        logic       prev_start;
        logic       fire;
        logic [7:0] cur;
        countdown  = 0;
        prev_start = 1'b0;
        cur        = '0;
        tile_done  = 1'b0;
        forever begin
            @(negedge map_clk);
            #1;
            tile_done = 1'b0;
            fire      = 1'b0;
            if (!rstn) begin
                countdown  = 0;
                prev_start = 1'b0;
            end else begin
                if (tile_start) begin
                    vectors++;
                    if (prev_start) begin
                        fails++;
                        $display("FAIL back_to_back: tile_start high two cycles running at (%0d,%0d)", grid_x, grid_y);
                    end
                    cur = {grid_y, grid_x};
                    starts.push_back(cur);
                    if (resp_en) countdown = (resp_fixed != 0) ? resp_fixed : int'($urandom_range(1, 4));
                    else         countdown = 0;
                end else if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) fire = 1'b1;
                end
                if (manual_done) begin
                    manual_done = 1'b0;
                    fire        = 1'b1;
                end
                if (fire) begin
                    vectors++;
                    if ({grid_y, grid_x} !== cur) begin
                        fails++;
                        $display("FAIL grid_hold: grid %h at done, required %h", {grid_y, grid_x}, cur);
                    end
                    tile_done = 1'b1;
                end
                prev_start = tile_start;
                #1;
                if (frame_done) begin
                    frames++;
                    frame_at.push_back(starts.size());
                end
            end
        end
    end

    task automatic do_mark(input logic [3:0] x, input logic [3:0] y);
        mark_valid = 1'b1;
        mark_x     = x;
        mark_y     = y;
        @(negedge map_clk);
        mark_valid = 1'b0;
    endtask

    task automatic pulse_full();
        full_req = 1'b1;
        @(negedge map_clk);
        full_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        repeat (2) @(negedge map_clk);
        while (busy && n < budget) begin
            @(negedge map_clk);
            n++;
        end
        repeat (2) @(negedge map_clk);
        vectors++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    // Checks that starts[base..] holds `count` row-major sweep cells back to back.
    task automatic check_sweeps(input int base, input int count, input string name);
        int bad;
        int n;
        vectors++;
        if (starts.size() - base !== count) begin
            fails++;
            $display("FAIL %s_count: %0d tile starts, required %0d", name, starts.size() - base, count);
        end
        n   = (starts.size() - base < count) ? starts.size() - base : count;
        bad = -1;
        for (int i = 0; i < n; i++)
            if (bad < 0 && starts[base + i] !== sweep_cell(i)) bad = i;
        vectors++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s_order: start %0d is %h, required %h", name, bad, starts[base + bad], sweep_cell(bad));
        end
    endtask

    task automatic test_reset();
        @(negedge map_clk);
        @(negedge map_clk);
        vectors++;
        if ({grid_y, grid_x, tile_start, frame_done, ovf, timeout_err} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: grid=%h start=%b frame=%b ovf=%b tmo=%b, required all 0",
                     {grid_y, grid_x}, tile_start, frame_done, ovf, timeout_err);
        end
        vectors++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_busy: busy=%b, required 1", busy);
        end
    endtask

    task automatic test_full_sweep();
        int base;
        int fb;
        base       = starts.size();
        fb         = frames;
        resp_fixed = 3;
        rstn       = 1'b1;
        wait_idle(1500, "first_sweep");
        check_sweeps(base, W * H, "first_sweep");
        vectors++;
        if (frames - fb !== 1 || frame_at.size() < 1 || frame_at[frame_at.size() - 1] !== base + W * H) begin
            fails++;
            $display("FAIL first_sweep_frame: %0d frame_done pulses, required 1 after start %0d", frames - fb, W * H);
        end
        resp_fixed = 0;
    endtask

    task automatic test_single_mark();
        int base;
        base       = starts.size();
        mark_valid = 1'b1;
        mark_x     = 4'd5;
        mark_y     = 4'd7;
        @(negedge map_clk);
        mark_valid = 1'b0;
        vectors++;
        if (tile_start !== 1'b0) begin
            fails++;
            $display("FAIL mark_early: tile_start=%b one cycle after mark, required 0", tile_start);
        end
        @(negedge map_clk);
        vectors++;
        if (tile_start !== 1'b1 || {grid_y, grid_x} !== 8'h75) begin
            fails++;
            $display("FAIL mark_latency: start=%b grid=%h two cycles after mark, required 1 and 75", tile_start, {grid_y, grid_x});
        end
        wait_idle(50, "single_mark");
        vectors++;
        if (starts.size() - base !== 1) begin
            fails++;
            $display("FAIL single_mark_count: %0d starts, required 1", starts.size() - base);
        end
    endtask

    task automatic test_invalid_mark();
        int base;
        base = starts.size();
        do_mark(4'd13, 4'd0);
        do_mark(4'd0, 4'd13);
        do_mark(4'd15, 4'd15);
        repeat (6) @(negedge map_clk);
        vectors++;
        if (starts.size() - base !== 0 || busy !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL invalid_mark: %0d starts busy=%b ovf=%b, required 0 0 0", starts.size() - base, busy, ovf);
        end
    endtask

    task automatic test_random_marks();
        int         base;
        int         n;
        int         bad;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] exp_q[$];
        for (int r = 0; r < 6; r++) begin
            base = starts.size();
            exp_q.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                x = 4'($urandom_range(0, 15));
                y = 4'($urandom_range(0, 15));
                if (x < W && y < H) exp_q.push_back({y, x});
                do_mark(x, y);
            end
            wait_idle(200, "random_marks");
            vectors++;
            bad = (starts.size() - base !== exp_q.size()) ? 0 : -1;
            for (int i = 0; i < exp_q.size() && bad < 0; i++)
                if (starts[base + i] !== exp_q[i]) bad = i;
            if (bad >= 0) begin
                fails++;
                $display("FAIL random_marks: round %0d, %0d starts vs %0d expected, first difference at %0d",
                         r, starts.size() - base, exp_q.size(), bad);
            end
        end
        vectors++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL random_marks_ovf: ovf=%b, required 0", ovf);
        end
    endtask

    task automatic test_full_pop();
        int         base;
        int         bad;
        logic [7:0] exp_q[$];
        base    = starts.size();
        resp_en = 1'b0;
        exp_q.push_back(8'h11);
        do_mark(4'd1, 4'd1);
        @(negedge map_clk);
        vectors++;
        if (tile_start !== 1'b1) begin
            fails++;
            $display("FAIL full_pop_first: tile_start=%b, required 1", tile_start);
        end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({4'd3, 4'(i + 2)});
            do_mark(4'(i + 2), 4'd3);
        end
        resp_en     = 1'b1;
        manual_done = 1'b1;
        @(negedge map_clk);
        exp_q.push_back(8'hCC);
        do_mark(4'd12, 4'd12);
        wait_idle(200, "full_pop");
        vectors++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL full_pop_ovf: ovf=%b, required 0", ovf);
        end
        vectors++;
        bad = (starts.size() - base !== exp_q.size()) ? 0 : -1;
        for (int i = 0; i < exp_q.size() && bad < 0; i++)
            if (starts[base + i] !== exp_q[i]) bad = i;
        if (bad >= 0) begin
            fails++;
            $display("FAIL full_pop_order: %0d starts vs %0d expected, first difference at %0d",
                     starts.size() - base, exp_q.size(), bad);
        end
    endtask

    task automatic test_full_req_mid();
        int   base;
        int   fb;
        logic hit;
        base = starts.size();
        fb   = frames;
        pulse_full();
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (tile_start && {grid_y, grid_x} === 8'h23) hit = 1'b1;
            else @(negedge map_clk);
        end
        vectors++;
        if (!hit) begin
            fails++;
            $display("FAIL mid_req_reach: tile (3,2) never started, required within 2000 cycles");
        end
        pulse_full();
        wait_idle(4000, "mid_req");
        check_sweeps(base, 2 * W * H, "mid_req");
        vectors++;
        if (frames - fb !== 2) begin
            fails++;
            $display("FAIL mid_req_frames: %0d frame_done pulses, required 2", frames - fb);
        end
    endtask

    task automatic test_overflow();
        int base;
        int fb;
        base = starts.size();
        fb   = frames;
        pulse_full();
        repeat (8) @(negedge map_clk);
        for (int i = 0; i < 8; i++) do_mark(4'(i), 4'd0);
        vectors++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_early: ovf=%b after 8 marks, required 0", ovf);
        end
        do_mark(4'd8, 4'd0);
        vectors++;
        if (ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: ovf=%b after 9th mark, required 1", ovf);
        end
        wait_idle(4000, "overflow");
        check_sweeps(base, 2 * W * H, "overflow");
        vectors++;
        if (frames - fb !== 2 || ovf !== 1'b1) begin
            fails++;
            $display("FAIL overflow_frames: %0d frames ovf=%b, required 2 and 1", frames - fb, ovf);
        end
    endtask

    task automatic test_timeout();
        int   base;
        int   fb;
        logic hit;
        base    = starts.size();
        fb      = frames;
        resp_en = 1'b0;
        pulse_full();
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (tile_start) hit = 1'b1;
            else @(negedge map_clk);
        end
        repeat (2040) @(negedge map_clk);
        vectors++;
        if (!hit || timeout_err !== 1'b0 || starts.size() - base !== 1) begin
            fails++;
            $display("FAIL timeout_early: seen=%b tmo=%b starts=%0d, required 1 0 1", hit, timeout_err, starts.size() - base);
        end
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (tile_start) hit = 1'b1;
            else @(negedge map_clk);
        end
        resp_en = 1'b1;
        vectors++;
        if (!hit || timeout_err !== 1'b1 || {grid_y, grid_x} !== 8'h01) begin
            fails++;
            $display("FAIL timeout_advance: seen=%b tmo=%b grid=%h, required 1 1 01", hit, timeout_err, {grid_y, grid_x});
        end
        wait_idle(3000, "timeout");
        check_sweeps(base, W * H, "timeout");
        vectors++;
        if (frames - fb !== 1 || timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_frame: %0d frames tmo=%b, required 1 and 1", frames - fb, timeout_err);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_single_mark();
        test_invalid_mark();
        test_random_marks();
        test_full_pop();
        test_full_req_mid();
        test_overflow();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
